// File: rtl/cavlc_level_encode.sv
// -----------------------------------------------------------------------------
// cavlc_level_encode
//
// Purpose:
//   Turns the nonzero coefficient levels of one CAVLC block into H.264 level
//   codewords. Trailing ones are sent as single sign bits. Every other level is
//   sent as level_prefix zeros, a one, and a level_suffix. The suffix length
//   adapts as the block is coded. One level is consumed per input handshake.
//   One right-aligned codeword and its length are produced per output
//   handshake.
//
// Ports:
//   Clk           clock
//   nReset        asynchronous reset, active-low
//   Start         one-cycle pulse in IDLE; latches TotalCoeff/TrailingOnes
//   TotalCoeff    number of nonzero coefficients in the block (0..16)
//   TrailingOnes  number of trailing +/-1 coefficients (0..3)
//   LevelIn       signed level in reverse scan order, trailing ones first
//   LevelValid    LevelIn is valid
//   LevelReady    a level is taken when LevelValid && LevelReady
//   CodeWord      codeword, right-aligned, MSB first at bit CodeLen-1
//   CodeLen       codeword length in bits (1..28)
//   CodeValid     CodeWord/CodeLen are valid
//   CodeReady     the packer takes the codeword when CodeValid && CodeReady
//   Done          one-cycle pulse once the block is fully emitted
//   Overflow      sticky flag: a level could not be represented exactly
//   TotalBits     bits emitted this block (present only with the macro below)
//
// Configuration:
//   CAVLC_LEVEL_BITCNT_EN  when defined, adds the TotalBits port and its
//                          saturating per-block bit counter.
// -----------------------------------------------------------------------------
module cavlc_level_encode (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        Start,
  input  logic [4:0]  TotalCoeff,
  input  logic [1:0]  TrailingOnes,
  input  logic [12:0] LevelIn,
  input  logic        LevelValid,
  output logic        LevelReady,
  output logic [27:0] CodeWord,
  output logic [4:0]  CodeLen,
  output logic        CodeValid,
  input  logic        CodeReady,
  output logic        Done,
  output logic        Overflow
`ifdef CAVLC_LEVEL_BITCNT_EN
  ,
  output logic [9:0]  TotalBits
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_T1,
    ST_LEVEL,
    ST_FLUSH
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [4:0]  total_coeff;
  logic [1:0]  trailing_ones;
  logic [4:0]  acc_cnt;
  logic [2:0]  suffix_len;

  logic        accept;
  logic        done_next;
  logic [4:0]  cnt_inc;

  logic        sign;
  logic [12:0] mag_raw;
  logic [12:0] mag;
  logic        first_level;
  logic        t1_lt3;
  logic        fix_level;
  logic [13:0] level_code_base;
  logic [13:0] level_code;

  logic [13:0] esc_thresh;
  logic [13:0] suffix_mask;
  logic [13:0] esc_val;
  logic [11:0] esc_suffix;
  logic [3:0]  short_suffix;
  logic        escape;
  logic        esc_ovf;
  logic [27:0] cw_enc;
  logic [4:0]  len_enc;

  logic [2:0]  sl_one;
  logic [12:0] adapt_thresh;
  logic [2:0]  sl_adapt;

  logic [27:0] out_word;
  logic [4:0]  out_len;

  // State register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, input handshake and the Done request.
  // Accepted levels are counted from the start of the block, so the
  // trailing-one phase ends when the count reaches TrailingOnes and the
  // block ends when it reaches TotalCoeff.
  always_comb begin
    state_next = state;
    LevelReady = 1'b0;
    done_next  = 1'b0;
    cnt_inc    = acc_cnt + 5'd1;

    if (state == ST_T1 || state == ST_LEVEL) begin
      LevelReady = !CodeValid || CodeReady;
    end
    accept = LevelValid && LevelReady;

    case (state)
      ST_IDLE: begin
        if (Start) begin
          if (TrailingOnes != 2'd0) begin
            state_next = ST_T1;
          end else if (TotalCoeff != 5'd0) begin
            state_next = ST_LEVEL;
          end else begin
            state_next = ST_FLUSH;
          end
        end
      end
      ST_T1: begin
        if (accept && cnt_inc == {3'b000, trailing_ones}) begin
          state_next = (total_coeff == {3'b000, trailing_ones}) ? ST_FLUSH : ST_LEVEL;
        end
      end
      ST_LEVEL: begin
        if (accept && cnt_inc == total_coeff) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // The block is done once the final codeword leaves the register.
        if (!CodeValid || CodeReady) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Level-to-levelCode mapping.
  // Zero levels cannot be coded. A first level of magnitude 1 cannot be
  // coded either when fewer than three trailing ones were sent, because that
  // value would have been a trailing one. Both cases become magnitude 2 with
  // the sign kept and are flagged. The first such level is offset by -2
  // because magnitude 1 is impossible there.
  always_comb begin
    sign            = LevelIn[12];
    mag_raw         = sign ? (~LevelIn + 13'd1) : LevelIn;
    first_level     = (state == ST_LEVEL) && (acc_cnt == {3'b000, trailing_ones});
    t1_lt3          = (trailing_ones != 2'd3);
    fix_level       = (mag_raw == 13'd0) || (first_level && t1_lt3 && mag_raw == 13'd1);
    mag             = fix_level ? 13'd2 : mag_raw;
    level_code_base = sign ? ({mag, 1'b0} - 14'd1) : ({mag, 1'b0} - 14'd2);
    level_code      = (first_level && t1_lt3) ? (level_code_base - 14'd2) : level_code_base;
  end

  // Prefix/suffix construction.
  // The codeword is written as the value of "1 followed by suffix". The
  // leading prefix zeros come only from CodeLen. An escape always uses
  // prefix 15 and a 12-bit suffix, for 28 bits in total.
  always_comb begin
    cw_enc       = '0;
    len_enc      = '0;
    escape       = 1'b0;
    esc_val      = '0;
    esc_ovf      = 1'b0;
    esc_suffix   = '0;
    short_suffix = level_code[3:0] - 4'd14;
    esc_thresh   = 14'd15 << suffix_len;
    suffix_mask  = (14'd1 << suffix_len) - 14'd1;

    if (suffix_len == 3'd0) begin
      if (level_code < 14'd14) begin
        cw_enc  = 28'd1;
        len_enc = level_code[4:0] + 5'd1;
      end else if (level_code < 14'd30) begin
        cw_enc  = {23'd0, 1'b1, short_suffix};
        len_enc = 5'd19;
      end else begin
        escape  = 1'b1;
        esc_val = level_code - 14'd30;
      end
    end else if (level_code < esc_thresh) begin
      cw_enc  = {14'd0, (14'd1 << suffix_len) | (level_code & suffix_mask)};
      len_enc = 5'(level_code >> suffix_len) + 5'd1 + {2'b00, suffix_len};
    end else begin
      escape  = 1'b1;
      esc_val = level_code - esc_thresh;
    end

    if (escape) begin
      esc_ovf    = (esc_val > 14'd4095);
      esc_suffix = esc_ovf ? 12'hFFF : esc_val[11:0];
      cw_enc     = {15'd0, 1'b1, esc_suffix};
      len_enc    = 5'd28;
    end
  end

  // Suffix-length adaptation after each level coded in the LEVEL phase.
  // The length first leaves zero. It then grows by one when the magnitude
  // exceeds 3 << (sL-1), up to a maximum of 6.
  always_comb begin
    sl_one       = (suffix_len == 3'd0) ? 3'd1 : suffix_len;
    adapt_thresh = 13'd3 << (sl_one - 3'd1);
    sl_adapt     = (mag > adapt_thresh && sl_one < 3'd6) ? (sl_one + 3'd1) : sl_one;
  end

  // A trailing one is just its sign bit (1 means -1).
  always_comb begin
    if (state == ST_T1) begin
      out_word = {27'd0, LevelIn[12]};
      out_len  = 5'd1;
    end else begin
      out_word = cw_enc;
      out_len  = len_enc;
    end
  end

  // Block context, the output register and the status flags.
  // The output register holds its codeword until the packer takes it. A
  // new level is only accepted when that frees the register in the same cycle.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      total_coeff   <= '0;
      trailing_ones <= '0;
      acc_cnt       <= '0;
      suffix_len    <= '0;
      CodeWord      <= '0;
      CodeLen       <= '0;
      CodeValid     <= 1'b0;
      Done          <= 1'b0;
      Overflow      <= 1'b0;
    end else begin
      if (state == ST_IDLE && Start) begin
        total_coeff   <= TotalCoeff;
        trailing_ones <= TrailingOnes;
        acc_cnt       <= '0;
        suffix_len    <= (TotalCoeff > 5'd10 && TrailingOnes != 2'd3) ? 3'd1 : 3'd0;
        Overflow      <= 1'b0;
      end

      if (accept) begin
        acc_cnt   <= cnt_inc;
        CodeWord  <= out_word;
        CodeLen   <= out_len;
        CodeValid <= 1'b1;
        if (state == ST_LEVEL) begin
          suffix_len <= sl_adapt;
          if (fix_level || esc_ovf) begin
            Overflow <= 1'b1;
          end
        end
      end else if (CodeReady) begin
        CodeValid <= 1'b0;
      end

      Done <= done_next;
    end
  end

`ifdef CAVLC_LEVEL_BITCNT_EN
  logic [10:0] bits_sum;

  assign bits_sum = {1'b0, TotalBits} + {6'd0, CodeLen};

  // Per-block bit count. It saturates at 1023 so a long block cannot wrap.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      TotalBits <= '0;
    end else if (state == ST_IDLE && Start) begin
      TotalBits <= '0;
    end else if (CodeValid && CodeReady) begin
      TotalBits <= (bits_sum > 11'd1023) ? 10'h3FF : bits_sum[9:0];
    end
  end
`endif

endmodule

// File: tb/tb_cavlc_level_encode.sv
// -----------------------------------------------------------------------------
// tb_cavlc_level_encode
//
// Self-checking bench for cavlc_level_encode. It drives directed blocks of
// levels. The expected codewords, lengths, flags and Done timing were worked
// out by hand.
// -----------------------------------------------------------------------------
module tb_cavlc_level_encode;

  logic        Clk = 1'b0;
  logic        nReset = 1'b1;
  logic        Start = 1'b0;
  logic [4:0]  TotalCoeff = '0;
  logic [1:0]  TrailingOnes = '0;
  logic [12:0] LevelIn = '0;
  logic        LevelValid = 1'b0;
  logic        LevelReady;
  logic [27:0] CodeWord;
  logic [4:0]  CodeLen;
  logic        CodeValid;
  logic        CodeReady = 1'b0;
  logic        Done;
  logic        Overflow;
`ifdef CAVLC_LEVEL_BITCNT_EN
  logic [9:0]  TotalBits;
`endif

  int total_checks = 0;
  int bad_checks   = 0;
  int cycle        = 0;
  int done_count   = 0;
  int done_cycle   = 0;
  int last_hs_cycle = 0;
  int start_cycle  = 0;
  int cap_base     = 0;
  logic [27:0] got_word[$];
  logic [4:0]  got_len[$];

  always #5 Clk = ~Clk;

  cavlc_level_encode dut (
    .Clk          (Clk),
    .nReset       (nReset),
    .Start        (Start),
    .TotalCoeff   (TotalCoeff),
    .TrailingOnes (TrailingOnes),
    .LevelIn      (LevelIn),
    .LevelValid   (LevelValid),
    .LevelReady   (LevelReady),
    .CodeWord     (CodeWord),
    .CodeLen      (CodeLen),
    .CodeValid    (CodeValid),
    .CodeReady    (CodeReady),
    .Done         (Done),
    .Overflow     (Overflow)
`ifdef CAVLC_LEVEL_BITCNT_EN
    ,
    .TotalBits    (TotalBits)
`endif
  );

  always @(posedge Clk) cycle <= cycle + 1;

  // Capture every output handshake and every Done pulse.
  always @(negedge Clk) begin
    if (CodeValid && CodeReady) begin
      got_word.push_back(CodeWord);
      got_len.push_back(CodeLen);
      last_hs_cycle = cycle;
    end
    if (Done) begin
      done_count++;
      done_cycle = cycle;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] tc, input logic [1:0] t1);
    @(posedge Clk); #1;
    TotalCoeff   = tc;
    TrailingOnes = t1;
    Start        = 1'b1;
    start_cycle  = cycle;
    cap_base     = got_word.size();
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic send_level(input logic [12:0] lvl);
    int wait_cycles = 0;
    LevelIn    = lvl;
    LevelValid = 1'b1;
    @(negedge Clk);
    while (!LevelReady && wait_cycles < 50) begin
      @(negedge Clk);
      wait_cycles++;
    end
    if (!LevelReady) checkOutput("levelReadyTimeout", 32'(LevelReady), 32'd1);
    @(posedge Clk); #1;
    LevelValid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int base = done_count;
    int n = 0;
    while (done_count == base && n < 100) begin
      @(negedge Clk);
      n++;
    end
    checkOutput({tag, "_doneCount"}, 32'(done_count - base), 32'd1);
    @(negedge Clk);
    checkOutput({tag, "_donePulse"}, 32'(Done), 32'd0);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [27:0] w, input logic [4:0] l);
    int pos = cap_base + idx;
    if (pos < got_word.size()) begin
      checkOutput({tag, "_word"}, 32'(got_word[pos]), 32'(w));
      checkOutput({tag, "_len"}, 32'(got_len[pos]), 32'(l));
    end else begin
      checkOutput({tag, "_present"}, 32'(got_word.size()), 32'(pos + 1));
    end
  endtask

  task automatic check_count(input string tag, input int n);
    checkOutput({tag, "_count"}, 32'(got_word.size() - cap_base), 32'(n));
  endtask

  // TotalCoeff=3, TrailingOnes=1, levels -1, 3, -2 -> (1,1) (001b,3) (011b,3)
  task automatic run_case_a(input string tag);
    applyStimulus(5'd3, 2'd1);
    send_level(-13'sd1);
    send_level(13'sd3);
    send_level(-13'sd2);
    wait_done(tag);
    check_count(tag, 3);
    check_word({tag, "_w0"}, 0, 28'h1, 5'd1);
    check_word({tag, "_w1"}, 1, 28'h1, 5'd3);
    check_word({tag, "_w2"}, 2, 28'h3, 5'd3);
    checkOutput({tag, "_doneLag"}, 32'(done_cycle - last_hs_cycle), 32'd1);
    checkOutput({tag, "_overflow"}, 32'(Overflow), 32'd0);
`ifdef CAVLC_LEVEL_BITCNT_EN
    checkOutput({tag, "_totalBits"}, 32'(TotalBits), 32'd7);
`endif
  endtask

  initial begin
    // Asynchronous reset values
    #2 nReset = 1'b0;
    #6;
    checkOutput("rst_levelReady", 32'(LevelReady), 32'd0);
    checkOutput("rst_codeWord", 32'(CodeWord), 32'd0);
    checkOutput("rst_codeLen", 32'(CodeLen), 32'd0);
    checkOutput("rst_codeValid", 32'(CodeValid), 32'd0);
    checkOutput("rst_done", 32'(Done), 32'd0);
    checkOutput("rst_overflow", 32'(Overflow), 32'd0);
`ifdef CAVLC_LEVEL_BITCNT_EN
    checkOutput("rst_totalBits", 32'(TotalBits), 32'd0);
`endif
    @(negedge Clk);
    nReset    = 1'b1;
    CodeReady = 1'b1;

    $display("[TB] basic block");
    run_case_a("caseA");

    // Three trailing ones, then 20 escapes with suffixLength 0: 0x1008, 28 bits
    $display("[TB] trailing ones and escape");
    applyStimulus(5'd4, 2'd3);
    send_level(13'sd1);
    send_level(13'sd1);
    send_level(-13'sd1);
    send_level(13'sd20);
    wait_done("caseB");
    check_count("caseB", 4);
    check_word("caseB_w0", 0, 28'h0, 5'd1);
    check_word("caseB_w1", 1, 28'h0, 5'd1);
    check_word("caseB_w2", 2, 28'h1, 5'd1);
    check_word("caseB_w3", 3, 28'h1008, 5'd28);

    // Adaptation 0->2->3 across levels 4, -7, 2, with a 5-cycle packer stall
    $display("[TB] output stall");
    applyStimulus(5'd3, 2'd0);
    send_level(13'sd4);
    CodeReady  = 1'b0;
    LevelIn    = -13'sd7;
    LevelValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checkOutput("stall_levelReady", 32'(LevelReady), 32'd0);
      checkOutput("stall_codeValid", 32'(CodeValid), 32'd1);
      checkOutput("stall_codeWord", 32'(CodeWord), 32'h1);
      checkOutput("stall_codeLen", 32'(CodeLen), 32'd5);
    end
    @(posedge Clk); #1;
    CodeReady = 1'b1;
    send_level(-13'sd7);
    send_level(13'sd2);
    wait_done("stall");
    check_count("stall", 3);
    check_word("stall_w0", 0, 28'h1, 5'd5);
    check_word("stall_w1", 1, 28'h5, 5'd6);
    check_word("stall_w2", 2, 28'hA, 5'd4);

    // A zero level is flagged and coded as +2 (levelCode 0 after the -2 offset)
    $display("[TB] zero level");
    applyStimulus(5'd1, 2'd0);
    send_level(13'sd0);
    wait_done("zero");
    check_count("zero", 1);
    check_word("zero_w0", 0, 28'h1, 5'd1);
    checkOutput("zero_overflow", 32'(Overflow), 32'd1);

    // Empty block: no codewords, Done two cycles after Start, Overflow cleared
    $display("[TB] empty block");
    applyStimulus(5'd0, 2'd0);
    wait_done("empty");
    check_count("empty", 0);
    checkOutput("empty_doneLag", 32'(done_cycle - start_cycle), 32'd2);
    checkOutput("empty_overflowCleared", 32'(Overflow), 32'd0);

    // -4095 with suffixLength 0: escape suffix saturates at 0xFFF
    $display("[TB] escape saturation");
    applyStimulus(5'd1, 2'd0);
    send_level(-13'sd4095);
    wait_done("sat");
    check_count("sat", 1);
    check_word("sat_w0", 0, 28'h1FFF, 5'd28);
    checkOutput("sat_overflow", 32'(Overflow), 32'd1);
`ifdef CAVLC_LEVEL_BITCNT_EN
    checkOutput("sat_totalBits", 32'(TotalBits), 32'd28);
`endif

    // TotalCoeff>10 starts at suffixLength 1; reset then drops the block
    $display("[TB] mid-block reset");
    applyStimulus(5'd11, 2'd0);
    send_level(13'sd5);
    send_level(13'sd1);
    send_level(13'sd1);
    check_word("big_w0", 0, 28'h2, 5'd5);
    check_word("big_w1", 1, 28'h4, 5'd3);
    nReset = 1'b0;
    #2;
    checkOutput("midrst_levelReady", 32'(LevelReady), 32'd0);
    checkOutput("midrst_codeWord", 32'(CodeWord), 32'd0);
    checkOutput("midrst_codeLen", 32'(CodeLen), 32'd0);
    checkOutput("midrst_codeValid", 32'(CodeValid), 32'd0);
    checkOutput("midrst_done", 32'(Done), 32'd0);
    checkOutput("midrst_overflow", 32'(Overflow), 32'd0);
    @(negedge Clk);
    nReset = 1'b1;

    $display("[TB] block after reset");
    run_case_a("afterRst");

    repeat (3) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/cavlc_level_encode.md
# cavlc_level_encode

Encodes the nonzero coefficient levels of one CAVLC block into H.264 level codewords: trailing-one sign bits, then level_prefix/level_suffix with adaptive suffixLength. Sits between the coefficient scan and the bitstream packer. It is the encoder-side counterpart of the level decoder. It consumes one level per handshake and emits one right-aligned codeword with its length per handshake.

## Interface
Parameters: none.

Ports:
- Clk  in  1  clock
- nReset  in  1  reset, asynchronous, active-low
- Start  in  1  one-cycle pulse in IDLE; latches TotalCoeff/TrailingOnes
- TotalCoeff  in  5  nonzero coefficients in block, 0..16
- TrailingOnes  in  2  trailing ±1 count, 0..3, ≤ TotalCoeff
- LevelIn  in  13  signed two's-complement level, reverse scan order, trailing ones first
- LevelValid  in  1  LevelIn valid
- LevelReady  out  1  level accepted when LevelValid && LevelReady
- CodeWord  out  28  codeword, right-aligned, MSB first at bit CodeLen-1
- CodeLen  out  5  codeword length, 1..28
- CodeValid  out  1  CodeWord/CodeLen valid
- CodeReady  in  1  packer accepts when CodeValid && CodeReady
- Done  out  1  one-cycle pulse when block complete
- Overflow  out  1  sticky; level unencodable in 12-bit escape suffix
- TotalBits  out  10  only with CAVLC_LEVEL_BITCNT_EN; bits emitted this block

## Operation
- FSM: IDLE, T1, LEVEL, FLUSH. Start in IDLE: latch counts, clear Overflow, suffixLength = (TotalCoeff>10 && TrailingOnes<3) ? 1 : 0. Next state T1 if TrailingOnes>0, else LEVEL if TotalCoeff>0, else FLUSH.
- T1: each accepted level emits 1 bit, CodeWord[0] = LevelIn[12] (1 = −1), CodeLen=1. After TrailingOnes accepts, go to LEVEL, or FLUSH if TotalCoeff==TrailingOnes.
- LEVEL: levelCode = level>0 ? 2·level−2 : −2·level−1, 14-bit unsigned. For the first LEVEL-state level with TrailingOnes<3, subtract 2.
- suffixLength 0: levelCode<14 gives prefix=levelCode, no suffix. levelCode<30 gives prefix 14 plus 4-bit suffix levelCode−14. Otherwise prefix 15 plus 12-bit suffix levelCode−30.
- suffixLength>0: levelCode < (15<<sL) gives prefix = levelCode>>sL plus sL-bit suffix levelCode mod 2^sL. Otherwise prefix 15 plus 12-bit suffix levelCode−(15<<sL).
- Codeword = prefix zeros, one 1, then suffix. CodeLen = prefix+1+suffixSize.
- Escape suffix >4095: saturate to 4095 and set Overflow.
- Adaptation after each LEVEL level: if sL==0 then sL=1. Then if |level| > (3<<(sL−1)) and sL<6, increment sL.
- After TotalCoeff accepts total, go to FLUSH. FLUSH waits until the output register is empty, pulses Done, and returns to IDLE.
- Level of 0, or first LEVEL-state level with |level|==1 and TrailingOnes<3: set Overflow, encode as |level|=2 with the sign preserved.
- Start outside IDLE is ignored. LevelValid in IDLE/FLUSH is ignored (LevelReady=0).

## Timing
- Reset values: LevelReady 0, CodeWord 0, CodeLen 0, CodeValid 0, Done 0, Overflow 0, TotalBits 0, state IDLE, suffixLength 0.
- Single output register. LevelReady = (state is T1 or LEVEL) && (!CodeValid || CodeReady), so full throughput is one level per cycle.
- Latency: a level accepted in cycle n gives CodeValid in n+1.
- CodeWord/CodeLen are held stable while CodeValid && !CodeReady.
- Done is asserted the cycle after the last codeword handshake, or 2 cycles after Start when TotalCoeff==0. It may coincide with Start being ignored.
- Async reset mid-block drops the pending codeword and returns to IDLE immediately.

## Configuration
- CAVLC_LEVEL_BITCNT_EN defined: TotalBits port present. Cleared on Start. Adds CodeLen on each codeword handshake and saturates at 1023. Valid when Done pulses.
- Not defined: port and counter are absent, and all other behaviour is identical.

## Test plan
- TotalCoeff=3, TrailingOnes=1, levels −1,3,−2, CodeReady=1 → codewords (1,len1), (001b,len3), (011b,len3). Done one cycle after the third.
- TotalCoeff=4, TrailingOnes=3, levels +1,+1,−1,20 → three 1-bit codes 0,0,1, then CodeWord=0x01008, CodeLen=28. suffixLength ends at 2.
- TotalCoeff=11, TrailingOnes=0, first level 5 → initial sL=1, levelCode=6, codeword 0001 0b, CodeLen=5.
- TotalCoeff=0 Start → no CodeValid, Done 2 cycles later. Level −4095 with sL=0 → Overflow=1, suffix 0xFFF.
- CodeReady held low 5 cycles mid-block → LevelReady=0, outputs stable, no codeword lost or duplicated.
- nReset pulsed mid-block → all outputs 0. A new Start encodes correctly. With CAVLC_LEVEL_BITCNT_EN, first case gives TotalBits=7.
